// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: register offsets, CTRL/STATUS bit
// positions and the measurement FSM encoding.
package pwm_capture_pkg;

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegPeriod  = 3'd1;
  localparam logic [2:0] RegHigh    = 3'd2;
  localparam logic [2:0] RegStatus  = 3'd3;
  localparam logic [2:0] RegTimeout = 3'd4;
  localparam logic [2:0] RegCount   = 3'd5;

  localparam int unsigned CtrlEnable    = 0;
  localparam int unsigned CtrlValidIe   = 1;
  localparam int unsigned CtrlTimeoutIe = 2;
  localparam int unsigned CtrlOverrunIe = 3;

  localparam int unsigned StatValid   = 0;
  localparam int unsigned StatTimeout = 1;
  localparam int unsigned StatOverrun = 2;
  localparam int unsigned StatLevel   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } capState_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Register bus between a fabric master and the PWM capture block.
interface pwm_capture_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en, bus_read_en, bus_addr, bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en, bus_read_en, bus_addr, bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/pwm_capture_edge_sync.sv
// Synchronizes the asynchronous PWM input and flags its rising and falling edges.
module pwm_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic nreset,
  input  logic pwm_in,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   delayedQ;

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      syncQ    <= '0;
      delayedQ <= 1'b0;
    end else begin
      syncQ    <= {syncQ[SYNC_STAGES-2:0], pwm_in};
      delayedQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign synced = syncQ[SYNC_STAGES-1];
  assign rise   = synced & ~delayedQ;
  assign fall   = ~synced & delayedQ;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input; results, read-clear status
// and a level interrupt are exposed through a small register file.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_RST = 32'h000F_FFFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         pclk,
  input  logic         nreset,
  pwm_capture_if.slave bus,
  output logic         fabint,
  input  logic         pwm_in
);

  logic synced, rise, fall;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .pclk  (pclk),
    .nreset(nreset),
    .pwm_in(pwm_in),
    .synced(synced),
    .rise  (rise),
    .fall  (fall)
  );

  capState_e   stateQ, stateD;
  logic [3:0]  ctrlQ, ctrlD;
  logic [31:0] timeoutQ, timeoutD;
  logic [31:0] periodQ, periodD;
  logic [31:0] highQ, highD;
  logic [31:0] countQ, countD;
  logic [31:0] cntQ, cntD;
  logic [31:0] hiShadowQ, hiShadowD;
  logic [31:0] rdataQ, rdataD;
  logic [31:0] readMux;
  logic [2:0]  statusQ, statusD;
  logic [2:0]  setBits;
  logic        clrPendQ, clrPendD;
  logic        fabintQ;

  logic [2:0] regSel;
  logic       wrEn, rdEn;
  logic       unusedAddr;

  assign regSel     = bus.bus_addr[4:2];
  assign wrEn       = bus.bus_write_en;
  // A simultaneous write wins; the read is dropped entirely, including its clear side effect.
  assign rdEn       = bus.bus_read_en & ~bus.bus_write_en;
  assign unusedAddr = ^{bus.bus_addr[7:5], bus.bus_addr[1:0]};

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    hiShadowD = hiShadowQ;
    periodD   = periodQ;
    highD     = highQ;
    countD    = countQ;
    setBits   = '0;
    if (!ctrlQ[CtrlEnable]) begin
      stateD    = StIdle;
      cntD      = '0;
      hiShadowD = '0;
    end else begin
      case (stateQ)
        StIdle: stateD = StArm;
        StArm: begin
          if (rise) begin
            stateD = StHigh;
            cntD   = '0;
          end
        end
        StHigh: begin
          // The edge cycle itself is counted, so captured values are cnt+1.
          if (fall) begin
            stateD    = StLow;
            hiShadowD = cntQ + 32'd1;
            cntD      = cntQ + 32'd1;
          end else if (cntQ == timeoutQ) begin
            stateD               = StArm;
            setBits[StatTimeout] = 1'b1;
          end else begin
            cntD = cntQ + 32'd1;
          end
        end
        StLow: begin
          if (rise) begin
            stateD               = StHigh;
            periodD              = cntQ + 32'd1;
            highD                = hiShadowQ;
            cntD                 = '0;
            countD               = countQ + 32'd1;
            setBits[StatValid]   = 1'b1;
            setBits[StatOverrun] = statusQ[StatValid];
          end else if (cntQ == timeoutQ) begin
            stateD               = StArm;
            setBits[StatTimeout] = 1'b1;
          end else begin
            cntD = cntQ + 32'd1;
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_comb begin
    readMux = '0;
    case (regSel)
      RegCtrl:    readMux = {28'd0, ctrlQ};
      RegPeriod:  readMux = periodQ;
      RegHigh:    readMux = highQ;
      RegStatus:  readMux = {28'd0, synced, statusQ};
      RegTimeout: readMux = timeoutQ;
      RegCount:   readMux = countQ;
      default:    readMux = '0;
    endcase
  end

  always_comb begin
    ctrlD    = ctrlQ;
    timeoutD = timeoutQ;
    rdataD   = rdataQ;
    if (wrEn) begin
      case (regSel)
        RegCtrl:    ctrlD    = bus.bus_write_data[3:0];
        RegTimeout: timeoutD = bus.bus_write_data;
        default:    ;
      endcase
    end
    if (rdEn) begin
      rdataD = readMux;
    end
    clrPendD = rdEn && (regSel == RegStatus);
    // New events land on top of a pending clear so none are lost.
    statusD  = (clrPendQ ? 3'b000 : statusQ) | setBits;
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      stateQ    <= StIdle;
      ctrlQ     <= '0;
      timeoutQ  <= TIMEOUT_RST;
      periodQ   <= '0;
      highQ     <= '0;
      countQ    <= '0;
      cntQ      <= '0;
      hiShadowQ <= '0;
      rdataQ    <= '0;
      statusQ   <= '0;
      clrPendQ  <= 1'b0;
      fabintQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      ctrlQ     <= ctrlD;
      timeoutQ  <= timeoutD;
      periodQ   <= periodD;
      highQ     <= highD;
      countQ    <= countD;
      cntQ      <= cntD;
      hiShadowQ <= hiShadowD;
      rdataQ    <= rdataD;
      statusQ   <= statusD;
      clrPendQ  <= clrPendD;
      fabintQ   <= |(statusQ & ctrlQ[CtrlOverrunIe:CtrlValidIe]);
    end
  end

  assign bus.bus_read_data = rdataQ;
  assign fabint            = fabintQ;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed and randomized checks of pwm_capture against a period/high-time model.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam logic [31:0] TimeoutRst = 32'h000F_FFFF;
  localparam int unsigned SyncStages = 2;

  logic pclk   = 1'b0;
  logic nreset = 1'b0;
  logic pwm_in = 1'b0;
  logic fabint;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelPeriod = '0;
  logic [31:0] modelHigh   = '0;
  logic [31:0] modelCount  = '0;

  pwm_capture_if bus ();

  pwm_capture #(
    .TIMEOUT_RST(TimeoutRst),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .pclk  (pclk),
    .nreset(nreset),
    .bus   (bus),
    .fabint(fabint),
    .pwm_in(pwm_in)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] addr_of(input logic [2:0] r);
    return {3'd0, r, 2'b00};
  endfunction

  // A completed measurement as the register file should report it.
  function automatic void model_complete(input int h, input int l);
    modelPeriod = h + l;
    modelHigh   = h;
    modelCount  = modelCount + 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] r, input logic [31:0] d);
    @(negedge pclk);
    bus.bus_addr       = addr_of(r);
    bus.bus_write_data = d;
    bus.bus_write_en   = 1'b1;
    @(posedge pclk);
    #1;
    bus.bus_write_en = 1'b0;
  endtask

  task automatic bus_wr_rd(input logic [2:0] r, input logic [31:0] d);
    @(negedge pclk);
    bus.bus_addr       = addr_of(r);
    bus.bus_write_data = d;
    bus.bus_write_en   = 1'b1;
    bus.bus_read_en    = 1'b1;
    @(posedge pclk);
    #1;
    bus.bus_write_en = 1'b0;
    bus.bus_read_en  = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] r, output logic [31:0] d);
    @(negedge pclk);
    bus.bus_addr    = addr_of(r);
    bus.bus_read_en = 1'b1;
    @(posedge pclk);
    #1;
    bus.bus_read_en = 1'b0;
    d = bus.bus_read_data;
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(r, v);
    check(tag, v, exp);
  endtask

  // Raises the input and spends exactly 9 cycles, optionally checking results on the way.
  task automatic rise_and_check(input bit chk, input string tag);
    pwm_in = 1'b1;
    cyc(6);
    if (chk) begin
      expect_reg({tag, "_period"}, RegPeriod, modelPeriod);
      expect_reg({tag, "_high"}, RegHigh, modelHigh);
      expect_reg({tag, "_count"}, RegCount, modelCount);
    end else begin
      cyc(3);
    end
  endtask

  task automatic pulse(input int h, input int l, input int spent);
    cyc(h - spent);
    pwm_in = 1'b0;
    cyc(l);
  endtask

  initial begin
    logic [31:0] v;
    int h, l, h2, l2;

    bus.bus_write_en   = 1'b0;
    bus.bus_read_en    = 1'b0;
    bus.bus_addr       = '0;
    bus.bus_write_data = '0;

    // Reset values
    cyc(3);
    check("rst_rdata", bus.bus_read_data, 32'd0);
    check("rst_fabint", 32'(fabint), 32'd0);
    nreset = 1'b1;
    cyc(2);
    expect_reg("rst_ctrl", RegCtrl, 32'd0);
    expect_reg("rst_period", RegPeriod, 32'd0);
    expect_reg("rst_high", RegHigh, 32'd0);
    expect_reg("rst_status", RegStatus, 32'd0);
    expect_reg("rst_timeout", RegTimeout, TimeoutRst);
    expect_reg("rst_count", RegCount, 32'd0);

    // Reserved slots and write-over-read priority
    bus_wr(3'd6, 32'hDEAD_BEEF);
    expect_reg("reserved_rd", 3'd6, 32'd0);
    bus_wr(RegCtrl, 32'hFFFF_FFF0);
    expect_reg("ctrl_upper_zero", RegCtrl, 32'd0);
    bus_wr_rd(RegTimeout, 32'h0000_1234);
    check("wr_rd_rdata_held", bus.bus_read_data, 32'd0);
    expect_reg("wr_rd_timeout", RegTimeout, 32'h0000_1234);
    bus_wr(RegTimeout, TimeoutRst);

    // 30 high / 70 low, three rises
    bus_wr(RegCtrl, 32'h3);
    cyc(3);
    rise_and_check(1'b0, "p0");
    pulse(30, 70, 9);
    model_complete(30, 70);
    rise_and_check(1'b1, "p1");
    expect_reg("p1_status", RegStatus, 32'h9);
    pulse(30, 70, 10);
    model_complete(30, 70);
    rise_and_check(1'b1, "p2");
    pulse(30, 70, 9);
    check("p2_fabint_set", 32'(fabint), 32'd1);
    expect_reg("p2_status", RegStatus, 32'h1);
    cyc(1);
    check("p2_fabint_hold", 32'(fabint), 32'd1);
    cyc(1);
    check("p2_fabint_clr", 32'(fabint), 32'd0);

    // Randomized periods
    bus_wr(RegCtrl, 32'h0);
    bus_rd(RegStatus, v);
    bus_wr(RegCtrl, 32'h1);
    cyc(3);
    h = 0;
    l = 0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) model_complete(h, l);
      rise_and_check(k > 0, "rand");
      if (k == 6) break;
      h = int'($urandom_range(60, 10));
      l = int'($urandom_range(60, 3));
      pulse(h, l, 9);
    end
    cyc(10);
    pwm_in = 1'b0;
    cyc(5);

    // Timeout while held high
    bus_wr(RegCtrl, 32'h0);
    bus_wr(RegTimeout, 32'd50);
    bus_rd(RegStatus, v);
    bus_wr(RegCtrl, 32'h5);
    cyc(3);
    pwm_in = 1'b1;
    cyc(53);
    expect_reg("tmo_before", RegStatus, 32'h8);
    expect_reg("tmo_set", RegStatus, 32'hA);
    check("tmo_fabint", 32'(fabint), 32'd1);
    expect_reg("tmo_period", RegPeriod, modelPeriod);
    // Back in ARM: a fall then rise must not complete a measurement.
    pwm_in = 1'b0;
    cyc(10);
    pwm_in = 1'b1;
    cyc(10);
    expect_reg("tmo_arm_count", RegCount, modelCount);

    // Overrun: two measurements without a STATUS read
    pwm_in = 1'b0;
    bus_wr(RegCtrl, 32'h0);
    bus_wr(RegTimeout, 32'd1000);
    bus_rd(RegStatus, v);
    bus_wr(RegCtrl, 32'h9);
    cyc(3);
    h  = int'($urandom_range(50, 10));
    l  = int'($urandom_range(50, 3));
    h2 = int'($urandom_range(50, 10));
    l2 = int'($urandom_range(50, 3));
    rise_and_check(1'b0, "ovr0");
    pulse(h, l, 9);
    model_complete(h, l);
    rise_and_check(1'b1, "ovr1");
    pulse(h2, l2, 9);
    model_complete(h2, l2);
    rise_and_check(1'b1, "ovr2");
    pulse(12, 8, 9);
    check("ovr_fabint", 32'(fabint), 32'd1);
    expect_reg("ovr_status", RegStatus, 32'h5);

    // Valid set on the very edge a STATUS clear lands: high 12, low 11
    cyc(2);
    pwm_in = 1'b1;
    cyc(1);
    expect_reg("race_first", RegStatus, 32'h0);
    cyc(1);
    expect_reg("race_valid_kept", RegStatus, 32'h9);
    model_complete(12, 11);
    expect_reg("race_period", RegPeriod, modelPeriod);
    expect_reg("race_high", RegHigh, modelHigh);

    // Reset pulse mid-HIGH
    nreset = 1'b0;
    #2;
    check("arst_rdata", bus.bus_read_data, 32'd0);
    check("arst_fabint", 32'(fabint), 32'd0);
    @(negedge pclk);
    #2;
    nreset = 1'b1;
    @(posedge pclk);
    #1;
    pwm_in = 1'b0;
    cyc(4);
    modelPeriod = '0;
    modelHigh   = '0;
    modelCount  = '0;
    expect_reg("arst_ctrl", RegCtrl, 32'd0);
    expect_reg("arst_period", RegPeriod, modelPeriod);
    expect_reg("arst_high", RegHigh, modelHigh);
    expect_reg("arst_count", RegCount, modelCount);
    expect_reg("arst_timeout", RegTimeout, TimeoutRst);
    expect_reg("arst_status", RegStatus, 32'h0);
    bus_wr(RegCtrl, 32'h1);
    cyc(2);
    h = int'($urandom_range(60, 10));
    l = int'($urandom_range(60, 3));
    rise_and_check(1'b0, "arst0");
    pulse(h, l, 9);
    model_complete(h, l);
    rise_and_check(1'b1, "arst1");

    // Enable dropped mid-LOW then restored: needs rise, full period, rise
    pulse(20, 10, 9);
    bus_wr(RegCtrl, 32'h0);
    bus_wr(RegCtrl, 32'h1);
    cyc(10);
    rise_and_check(1'b1, "reen0");
    pulse(20, 25, 9);
    model_complete(20, 25);
    rise_and_check(1'b1, "reen1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
